// File: rtl/a78_loader_if.sv
// a78_loader_if: MiSTer ioctl download handshake.
//   ioctl_download  source -> loader  high for the whole file transfer
//   ioctl_wr        source -> loader  one-cycle byte strobe
//   ioctl_dout      source -> loader  download byte, valid with ioctl_wr
//   ioctl_wait      loader -> source  stall request
// master: download source side; slave: loader side.
interface a78_loader_if;
    logic       ioctl_download;
    logic       ioctl_wr;
    logic [7:0] ioctl_dout;
    logic       ioctl_wait;

    modport master (
        output ioctl_download,
        output ioctl_wr,
        output ioctl_dout,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_wr,
        input  ioctl_dout,
        output ioctl_wait
    );
endinterface

// File: rtl/a78_loader.sv
// a78_loader: turns the ioctl download stream into byte writes for the cartridge RAM.
// The first ten bytes are held back until the A78 magic can be checked; a matching file
// has its 128-byte header stripped (size/type latched), otherwise the held bytes are
// replayed into RAM at addresses 0..9 while the source is stalled.
// Ports:
//   clk_sys, reset_n  clock, asynchronous active-low reset
//   ioctl             download handshake (slave side)
//   ram_addr/data/wren  single-cycle RAM write port
//   hdr_valid, cart_size, cart_type  header results
//   load_done         level, set at the end of a download
//   overflow          sticky per download, a data byte fell beyond the RAM
module a78_loader #(
    parameter int unsigned AW = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    a78_loader_if.slave   ioctl,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_data,
    output logic          ram_wren,
    output logic          hdr_valid,
    output logic [31:0]   cart_size,
    output logic [15:0]   cart_type,
    output logic          load_done,
    output logic          overflow
);

    localparam logic [71:0] Magic = 72'h41_54_41_52_49_37_38_30_30; // "ATARI7800"

    typedef enum logic [2:0] {StIdle, StCheck, StFlush, StHeader, StData, StDone} state_e;

    state_e        state_q;
    logic [24:0]   cnt_q;
    logic [7:0]    hbuf_q [10];
    logic [3:0]    flush_idx_q;
    logic [3:0]    flush_len_q;
    logic          dl_q;
    logic          wait_q;
    logic [AW-1:0] ram_addr_q;
    logic [7:0]    ram_data_q;
    logic          ram_wren_q;
    logic          hdr_valid_q;
    logic [31:0]   cart_size_q;
    logic [15:0]   cart_type_q;
    logic          load_done_q;
    logic          overflow_q;

    logic        dl_rise;
    logic        dl_fall;
    logic        accept;
    logic [24:0] data_addr;
    logic        addr_oob;
    logic        magic_ok;

    always_comb begin
        dl_rise   = ioctl.ioctl_download & ~dl_q;
        dl_fall   = ~ioctl.ioctl_download & dl_q;
        accept    = ioctl.ioctl_wr & ioctl.ioctl_download;
        data_addr = cnt_q - (hdr_valid_q ? 25'd128 : 25'd0);
        addr_oob  = (data_addr >> AW) != 25'd0;
        // Byte 9 is still on the bus when the comparison is made; byte 0 is ignored.
        magic_ok  = {hbuf_q[1], hbuf_q[2], hbuf_q[3], hbuf_q[4], hbuf_q[5],
                     hbuf_q[6], hbuf_q[7], hbuf_q[8], ioctl.ioctl_dout} == Magic;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            for (int i = 0; i < 10; i++) hbuf_q[i] <= '0;
            flush_idx_q <= '0;
            flush_len_q <= '0;
            dl_q        <= 1'b0;
            wait_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_wren_q  <= 1'b0;
            hdr_valid_q <= 1'b0;
            cart_size_q <= '0;
            cart_type_q <= '0;
            load_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            dl_q       <= ioctl.ioctl_download;
            ram_wren_q <= 1'b0;
            if (dl_rise) begin
                // A new download aborts whatever was in progress, flush included.
                state_q     <= StCheck;
                hdr_valid_q <= 1'b0;
                cart_size_q <= '0;
                cart_type_q <= '0;
                load_done_q <= 1'b0;
                overflow_q  <= 1'b0;
                wait_q      <= 1'b0;
                flush_idx_q <= '0;
                flush_len_q <= '0;
                if (accept) begin
                    hbuf_q[0] <= ioctl.ioctl_dout;
                    cnt_q     <= 25'd1;
                end else begin
                    cnt_q <= '0;
                end
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                    end
                    StCheck: begin
                        if (dl_fall) begin
                            if (cnt_q == 25'd0) begin
                                state_q     <= StDone;
                                load_done_q <= 1'b1;
                            end else begin
                                // Short file: replay what was buffered, first write now.
                                ram_wren_q  <= 1'b1;
                                ram_addr_q  <= '0;
                                ram_data_q  <= hbuf_q[0];
                                flush_idx_q <= 4'd1;
                                flush_len_q <= cnt_q[3:0];
                                wait_q      <= 1'b1;
                                state_q     <= StFlush;
                            end
                        end else if (accept) begin
                            hbuf_q[cnt_q[3:0]] <= ioctl.ioctl_dout;
                            cnt_q              <= cnt_q + 25'd1;
                            if (cnt_q == 25'd9) begin
                                if (magic_ok) begin
                                    hdr_valid_q <= 1'b1;
                                    state_q     <= StHeader;
                                end else begin
                                    ram_wren_q  <= 1'b1;
                                    ram_addr_q  <= '0;
                                    ram_data_q  <= hbuf_q[0];
                                    flush_idx_q <= 4'd1;
                                    flush_len_q <= 4'd10;
                                    wait_q      <= 1'b1;
                                    state_q     <= StFlush;
                                end
                            end
                        end
                    end
                    StFlush: begin
                        if (flush_idx_q < flush_len_q) begin
                            ram_wren_q  <= 1'b1;
                            ram_addr_q  <= AW'(flush_idx_q);
                            ram_data_q  <= hbuf_q[flush_idx_q];
                            flush_idx_q <= flush_idx_q + 4'd1;
                        end else begin
                            // Release the stall one cycle after the last write.
                            wait_q <= 1'b0;
                            if (!ioctl.ioctl_download) begin
                                state_q     <= StDone;
                                load_done_q <= 1'b1;
                                cart_size_q <= {7'd0, cnt_q};
                            end else begin
                                state_q <= StData;
                            end
                        end
                    end
                    StHeader: begin
                        if (dl_fall) begin
                            state_q     <= StDone;
                            load_done_q <= 1'b1;
                        end else if (accept) begin
                            cnt_q <= cnt_q + 25'd1;
                            if (cnt_q >= 25'd49 && cnt_q <= 25'd52)
                                cart_size_q <= {cart_size_q[23:0], ioctl.ioctl_dout};
                            if (cnt_q == 25'd53 || cnt_q == 25'd54)
                                cart_type_q <= {cart_type_q[7:0], ioctl.ioctl_dout};
                            if (cnt_q == 25'd127)
                                state_q <= StData;
                        end
                    end
                    StData: begin
                        if (dl_fall) begin
                            state_q     <= StDone;
                            load_done_q <= 1'b1;
                            if (!hdr_valid_q) cart_size_q <= {7'd0, cnt_q};
                        end else if (accept) begin
                            cnt_q <= cnt_q + 25'd1;
                            if (addr_oob) begin
                                overflow_q <= 1'b1;
                            end else begin
                                ram_wren_q <= 1'b1;
                                ram_addr_q <= data_addr[AW-1:0];
                                ram_data_q <= ioctl.ioctl_dout;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign ioctl.ioctl_wait = wait_q;
    assign ram_addr         = ram_addr_q;
    assign ram_data         = ram_data_q;
    assign ram_wren         = ram_wren_q;
    assign hdr_valid        = hdr_valid_q;
    assign cart_size        = cart_size_q;
    assign cart_type        = cart_type_q;
    assign load_done        = load_done_q;
    assign overflow         = overflow_q;

endmodule
